uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit path (the TX FIFO write port `w_data`/`wr_uart`/`tx_full`) among `N_REQ` independent byte-stream requesters. A requester that wins the grant keeps it for a whole packet, which ends at the byte flagged `last`. Packets from different sources therefore never interleave on the serial line. A watchdog releases the grant from a requester that stalls mid-packet. The block sits between the system-side message producers and the existing `uart` top's transmit interface.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DBIT`, 8: data bits per byte; must match the UART `DBIT`.
- `TIMEOUT`, 1024: number of consecutive idle cycles of a granted requester before the grant is forcibly released. Must be ≥1.

- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  N_REQ*DBIT  per-requester byte. Requester i occupies bits [i*DBIT +: DBIT].
- `req_last`  in  N_REQ  byte is the final byte of the packet.
- `req_ready`  out  N_REQ  byte accepted this cycle when `req_valid[i]` is also high.
- `w_data`  out  DBIT  to the UART TX FIFO `w_data`.
- `wr_uart`  out  1  to the UART TX FIFO `wr_uart`.
- `tx_full`  in  1  from the UART TX FIFO `tx_full`.
- `grant_id`  out  $clog2(N_REQ)  index of the current or most recent grant holder.
- `busy`  out  1  a grant is held (state GRANT).
- `abort`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- FSM states: IDLE and GRANT.
- In IDLE:
  - If any `req_valid` is high, pick the winner by round-robin. The search starts at `(last_grant+1) mod N_REQ` and wraps.
  - Register the winner into `grant_id` and `last_grant`, then go to GRANT.
  - No byte is accepted while in IDLE.
- In GRANT, with g = `grant_id`:
  - `req_ready[g] = !tx_full`. All other `req_ready` bits are 0.
  - `wr_uart = req_valid[g] & !tx_full`.
  - `w_data = req_data[g]`; the value is a don't-care when `wr_uart` is 0.
  - A byte is accepted when `wr_uart` = 1. If it also has `req_last[g]` = 1, go to IDLE next cycle.
- Watchdog:
  - The counter clears to 0 on every accepted byte and on entry to GRANT.
  - It increments in each GRANT cycle with `req_valid[g]` = 0.
  - Cycles where `tx_full` is high and `req_valid[g]` is high do not count, because backpressure is not a stall.
  - When the counter reaches `TIMEOUT`: pulse `abort` for 1 cycle, go to IDLE, and accept no byte in that cycle.
  - The aborted requester keeps its `last_grant` position, so the next arbitration skips past it.
- A `req_last` byte that is presented but not accepted has no effect.
- Requests from non-granted requesters are ignored. They are held off by `req_ready`=0 and must keep their data stable (valid/ready rule).
- Reset:
  - state = IDLE, `last_grant` = N_REQ-1 (requester 0 wins first), `grant_id` = 0, watchdog counter = 0.
  - Outputs: `busy` = 0, `abort` = 0, `wr_uart` = 0, `req_ready` = 0, `w_data` = 0.
  - Reset asserted mid-packet drops the grant immediately. A partial packet may already be in the FIFO; handling it is the upstream's responsibility.

## Timing
- `wr_uart`, `w_data` and `req_ready` are combinational from the registered state, `grant_id`, `req_valid` and `tx_full`. There is no registered output stage, so the FIFO can never be overfilled.
- Arbitration latency: request in IDLE at cycle t → GRANT at t+1 → first byte can be written at t+1.
- Throughput within a packet: 1 byte/cycle while `tx_full` = 0.
- Packet end: `last` accepted at t → IDLE at t+1 → new grant at t+2. This gives a fixed 1-cycle bubble between packets.
- Single-byte packet: grant at t+1, byte accepted at t+1, IDLE at t+2.
- `abort` asserts in the cycle the counter equals `TIMEOUT`. `busy` is 0 on the following cycle.
- `tx_full` rising while `req_valid[g]` = 1 stalls with no byte lost. The transfer resumes the cycle `tx_full` falls.

## Structure
- Shared package `uart_pkg`: `DBIT` default, FSM state typedef (`IDLE`, `GRANT`), and a `clog2`-based index width helper.
- One sub-module, `uart_rr_pick`:
  - Purely combinational rotating-priority encoder.
  - Inputs: request vector and `last_grant`.
  - Outputs: `any` flag and winner index.
- FSM, watchdog and output muxing live in `uart_tx_arbiter`.

## Test plan
- Single packet: requester 2 sends 0x41, 0x42, 0x43 (last on 0x43) with `tx_full`=0. Required: `wr_uart` high 3 consecutive cycles carrying 0x41/0x42/0x43, `grant_id`=2, `busy` drops the cycle after 0x43.
- Fairness: all 4 requesters hold valid 2-byte packets continuously from reset. Required: grant order 0,1,2,3,0; no interleaving; exactly one bubble cycle between packets.
- Backpressure: `tx_full` held high for 5 cycles mid-packet from requester 1. Required: `wr_uart`=0 and `req_ready[1]`=0 for those 5 cycles, no `abort`, no byte lost or duplicated.
- Watchdog: with `TIMEOUT`=8, requester 0 sends 1 byte without last, then drops valid. Required: `abort` pulses exactly 8 cycles later, `busy`→0, next grant goes to requester 1 if it is requesting.
- Reset mid-packet: assert `reset` for 1 cycle during byte 2 of a 4-byte packet. Required: all outputs at reset values next cycle, and requester 0 wins the first arbitration after release.
- Non-granted hold-off: requester 3 is valid while requester 1 is mid-packet. Required: `req_ready[3]`=0 until requester 1's last byte, then requester 3 is granted 2 cycles later.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, arbiter FSM state type and index-width helper
package uart_pkg;
  localparam int DBIT_DEF = 8;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotating-priority encoder, search starts just after last_grant and wraps
module uart_rr_pick import uart_pkg::*; #(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last_grant) + k) % N);
      idx = req[j] ? j : idx;
    end
    any = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART TX FIFO port, with stall watchdog
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DBIT = DBIT_DEF,
  parameter int TIMEOUT = 1024,
  localparam int GW = idx_w(N_REQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic [N_REQ-1:0]  req_last,
  output logic [N_REQ-1:0]  req_ready,
  output logic [DBIT-1:0]   w_data,
  output logic              wr_uart,
  input  logic              tx_full,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              abort
);
  state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic any, valid_g;
  uart_rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req(req_valid),
    .last_grant(last_q),
    .any(any),
    .idx(win)
  );
  always_comb begin
    valid_g = req_valid[grant_q];
    busy = state_q == GRANT;
    abort = busy && !valid_g && cnt_q == CW'(TIMEOUT - 1);
    wr_uart = busy && valid_g && !tx_full;
    req_ready = busy && !tx_full ? N_REQ'(1) << grant_q : '0;
    w_data = busy ? req_data[grant_q*DBIT +: DBIT] : '0;
    grant_id = grant_q;
    state_d = busy ? ((abort || (wr_uart && req_last[grant_q])) ? IDLE : GRANT) : (any ? GRANT : IDLE);
    grant_d = !busy && any ? win : grant_q;
    last_d = !busy && any ? win : last_q;
    cnt_d = !busy || wr_uart ? '0 : !valid_g ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(N_REQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus hand sequences for fairness, watchdog and reset
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8, TO = 8;
  typedef struct {
    logic r;
    logic [3:0] v;
    logic [31:0] d;
    logic [3:0] l;
    logic f;
    logic [3:0] rdy;
    logic wr;
    logic [7:0] wd;
    logic cwd;
    logic [1:0] gid;
    logic b;
    logic ab;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0] w_data;
  logic wr_uart, busy, abort;
  logic tx_full = 1'b0;
  logic [1:0] grant_id;
  int checks = 0, failures = 0;
  vec_t tbl[22];
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N_REQ(N), .DBIT(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .w_data(w_data),
    .wr_uart(wr_uart),
    .tx_full(tx_full),
    .grant_id(grant_id),
    .busy(busy),
    .abort(abort)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t t, input string tag);
    @(negedge clk);
    reset = t.r;
    req_valid = t.v;
    req_data = t.d;
    req_last = t.l;
    tx_full = t.f;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(t.rdy));
    chk({tag, " wr_uart"}, 32'(wr_uart), 32'(t.wr));
    if (t.cwd) chk({tag, " w_data"}, 32'(w_data), 32'(t.wd));
    chk({tag, " grant_id"}, 32'(grant_id), 32'(t.gid));
    chk({tag, " busy"}, 32'(busy), 32'(t.b));
    chk({tag, " abort"}, 32'(abort), 32'(t.ab));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_full = 1'b0;
  endtask
  initial begin
    logic [3:0] bidx;
    logic [31:0] d;
    logic [3:0] l;
    int g, ph;
    tbl[0]  = '{0, 4'b0100, 32'h0041_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd0, 0, 0};
    tbl[1]  = '{0, 4'b0100, 32'h0041_0000, 4'b0000, 0, 4'b0100, 1, 8'h41, 1, 2'd2, 1, 0};
    tbl[2]  = '{0, 4'b0100, 32'h0042_0000, 4'b0000, 0, 4'b0100, 1, 8'h42, 1, 2'd2, 1, 0};
    tbl[3]  = '{0, 4'b0100, 32'h0043_0000, 4'b0100, 0, 4'b0100, 1, 8'h43, 1, 2'd2, 1, 0};
    tbl[4]  = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd2, 0, 0};
    tbl[5]  = '{0, 4'b0010, 32'h0000_1000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd2, 0, 0};
    tbl[6]  = '{0, 4'b0010, 32'h0000_1000, 4'b0000, 0, 4'b0010, 1, 8'h10, 1, 2'd1, 1, 0};
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{0, 4'b0010, 32'h0000_1100, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 2'd1, 1, 0};
    tbl[12] = '{0, 4'b0010, 32'h0000_1100, 4'b0000, 0, 4'b0010, 1, 8'h11, 1, 2'd1, 1, 0};
    tbl[13] = '{0, 4'b0010, 32'h0000_1200, 4'b0010, 0, 4'b0010, 1, 8'h12, 1, 2'd1, 1, 0};
    tbl[14] = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0, 0};
    tbl[15] = '{0, 4'b0010, 32'h0000_2000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0, 0};
    tbl[16] = '{0, 4'b1010, 32'h3300_2000, 4'b0000, 0, 4'b0010, 1, 8'h20, 1, 2'd1, 1, 0};
    tbl[17] = '{0, 4'b1010, 32'h3300_2100, 4'b1000, 0, 4'b0010, 1, 8'h21, 1, 2'd1, 1, 0};
    tbl[18] = '{0, 4'b1010, 32'h3300_2200, 4'b1010, 0, 4'b0010, 1, 8'h22, 1, 2'd1, 1, 0};
    tbl[19] = '{0, 4'b1000, 32'h3300_0000, 4'b1000, 0, 4'b0000, 0, 8'h00, 1, 2'd1, 0, 0};
    tbl[20] = '{0, 4'b1000, 32'h3300_0000, 4'b1000, 0, 4'b1000, 1, 8'h33, 1, 2'd3, 1, 0};
    tbl[21] = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd3, 0, 0};
    do_reset();
    for (int i = 0; i < 22; i++) run(tbl[i], $sformatf("vec%0d", i));
    do_reset();
    bidx = '0;
    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < N; i++) begin
        d[i*8 +: 8] = 8'(i * 16) | 8'(bidx[i]);
        l[i] = bidx[i];
      end
      ph = k % 3;
      g = ph == 0 ? (k == 0 ? 0 : ((k / 3) - 1) % 4) : (k / 3) % 4;
      run('{0, 4'b1111, d, l, 0, ph != 0 ? 4'(1 << g) : 4'b0000, ph != 0, ph != 0 ? 8'(g * 16 + ph - 1) : 8'h00, 1, 2'(g), ph != 0, 0}, $sformatf("fair%0d", k));
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) bidx[i] = ~bidx[i];
    end
    do_reset();
    run('{0, 4'b0011, 32'h0000_B0A0, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd0, 0, 0}, "wdog0");
    run('{0, 4'b0011, 32'h0000_B0A0, 4'b0000, 0, 4'b0001, 1, 8'hA0, 1, 2'd0, 1, 0}, "wdog1");
    for (int k = 2; k <= 8; k++)
      run('{0, 4'b0010, 32'h0000_B0A0, 4'b0000, 0, 4'b0001, 0, 8'h00, 0, 2'd0, 1, 0}, $sformatf("wdog%0d", k));
    run('{0, 4'b0010, 32'h0000_B0A0, 4'b0000, 0, 4'b0001, 0, 8'h00, 0, 2'd0, 1, 1}, "wdog9");
    run('{0, 4'b0010, 32'h0000_B0A0, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd0, 0, 0}, "wdog10");
    run('{0, 4'b0010, 32'h0000_B0A0, 4'b0000, 0, 4'b0010, 1, 8'hB0, 1, 2'd1, 1, 0}, "wdog11");
    do_reset();
    run('{0, 4'b0100, 32'h00C0_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd0, 0, 0}, "rst0");
    run('{0, 4'b0100, 32'h00C0_0000, 4'b0000, 0, 4'b0100, 1, 8'hC0, 1, 2'd2, 1, 0}, "rst1");
    run('{1, 4'b0100, 32'h00C1_0000, 4'b0000, 0, 4'b0100, 1, 8'hC1, 1, 2'd2, 1, 0}, "rst2");
    run('{0, 4'b0101, 32'h00C2_00D0, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd0, 0, 0}, "rst3");
    run('{0, 4'b0101, 32'h00C2_00D0, 4'b0000, 0, 4'b0001, 1, 8'hD0, 1, 2'd0, 1, 0}, "rst4");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
